// File: rtl/vault_pkg.sv
// Shared definitions for the vault code-lock sequencer: state encoding.
package vault_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ENTER   = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_LOCKOUT = 3'd4
    } vault_state_e;

endpackage

// File: rtl/vault_code_mem.sv
// Code table: one secret symbol per position.
// Synchronous write, combinational read, cleared to zero on reset.
module vault_code_mem #(
    parameter int SYM_W = 4,
    parameter int DEPTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [SYM_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [SYM_W-1:0] rdata
);

    logic [SYM_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vault_lock_seq.sv
// Code-lock sequencer: checks a symbol sequence against the code table, counts
// failed attempts and locks out. Define VAULT_TIMEOUT_EN for the inter-symbol timeout.
module vault_lock_seq
    import vault_pkg::*;
#(
    parameter int SYM_W       = 4,
    parameter int DEPTH       = 8,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYC    = 16,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic [$clog2(DEPTH)-1:0]         cfg_addr,
    input  logic [SYM_W-1:0]                 cfg_data,
    input  logic                             arm,
    input  logic [$clog2(DEPTH+1)-1:0]       len_in,
    input  logic                             sym_valid,
    input  logic [SYM_W-1:0]                 sym_in,
    output logic                             busy,
    output logic [$clog2(DEPTH+1)-1:0]       progress,
    output logic                             done,
    output logic                             fail,
    output logic                             locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH+1);
    localparam int TW = $clog2(MAX_TRIES+1);
    localparam int LW = $clog2(LOCK_CYC+1);

    vault_state_e   state, state_nx;
    logic [PW-1:0]  progress_nx;
    logic [PW-1:0]  len_q, len_nx;
    logic [TW-1:0]  tries_nx;
    logic [LW-1:0]  lock_cnt, lock_nx;
    logic [SYM_W-1:0] code_sym;

`ifdef VAULT_TIMEOUT_EN
    localparam int TMW = $clog2(TIMEOUT_CYC+1);
    logic [TMW-1:0] tmo_cnt, tmo_nx;
`endif

    // Writes only land while idle, so an attempt in flight sees a stable table.
    vault_code_mem #(
        .SYM_W (SYM_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_code_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we && (state == ST_IDLE)),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (progress[AW-1:0]),
        .rdata (code_sym)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            progress   <= '0;
            len_q      <= '0;
            tries_left <= TW'(MAX_TRIES);
            lock_cnt   <= '0;
`ifdef VAULT_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            state      <= state_nx;
            progress   <= progress_nx;
            len_q      <= len_nx;
            tries_left <= tries_nx;
            lock_cnt   <= lock_nx;
`ifdef VAULT_TIMEOUT_EN
            tmo_cnt    <= tmo_nx;
`endif
        end
    end

    // tries_left is updated on entry to PASS/FAIL, so it is already current
    // during the single done/fail cycle.
    always_comb begin
        state_nx    = state;
        progress_nx = progress;
        len_nx      = len_q;
        tries_nx    = tries_left;
        lock_nx     = lock_cnt;
`ifdef VAULT_TIMEOUT_EN
        tmo_nx      = tmo_cnt;
`endif
        unique case (state)
            ST_IDLE: begin
                if (arm) begin
                    if ((len_in == '0) || (len_in > PW'(DEPTH))) begin
                        state_nx = ST_FAIL;
                        tries_nx = tries_left - TW'(1);
                    end else begin
                        state_nx    = ST_ENTER;
                        progress_nx = '0;
                        len_nx      = len_in;
`ifdef VAULT_TIMEOUT_EN
                        tmo_nx      = '0;
`endif
                    end
                end
            end
            ST_ENTER: begin
                if (sym_valid) begin
                    if (sym_in != code_sym) begin
                        state_nx = ST_FAIL;
                        tries_nx = tries_left - TW'(1);
                    end else if ((progress + PW'(1)) == len_q) begin
                        state_nx = ST_PASS;
                        tries_nx = TW'(MAX_TRIES);
                    end else begin
                        progress_nx = progress + PW'(1);
`ifdef VAULT_TIMEOUT_EN
                        tmo_nx      = '0;
`endif
                    end
                end
`ifdef VAULT_TIMEOUT_EN
                else if (tmo_cnt == TMW'(TIMEOUT_CYC - 1)) begin
                    state_nx = ST_FAIL;
                    tries_nx = tries_left - TW'(1);
                end else begin
                    tmo_nx = tmo_cnt + TMW'(1);
                end
`endif
            end
            ST_PASS: begin
                state_nx = ST_IDLE;
            end
            ST_FAIL: begin
                if (tries_left == '0) begin
                    state_nx = ST_LOCKOUT;
                    lock_nx  = '0;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt == LW'(LOCK_CYC - 1)) begin
                    state_nx = ST_IDLE;
                    tries_nx = TW'(MAX_TRIES);
                end else begin
                    lock_nx = lock_cnt + LW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state != ST_IDLE);
    assign done   = (state == ST_PASS);
    assign fail   = (state == ST_FAIL);
    assign locked = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_vault_lock_seq.sv
// Directed self-checking bench for vault_lock_seq (default parameters);
// timeout expectations follow whether VAULT_TIMEOUT_EN is defined.
module tb_vault_lock_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [3:0] cfg_data;
    logic       arm;
    logic [3:0] len_in;
    logic       sym_valid;
    logic [3:0] sym_in;
    logic       busy;
    logic [3:0] progress;
    logic       done;
    logic       fail;
    logic       locked;
    logic [1:0] tries_left;

    int checks = 0;
    int errors = 0;

    vault_lock_seq dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .arm        (arm),
        .len_in     (len_in),
        .sym_valid  (sym_valid),
        .sym_in     (sym_in),
        .busy       (busy),
        .progress   (progress),
        .done       (done),
        .fail       (fail),
        .locked     (locked),
        .tries_left (tries_left)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, let the edge take them, sample 1 ns later.
    task automatic applyStimulus(input logic we, input logic [2:0] addr, input logic [3:0] data,
                                 input logic a, input logic [3:0] len,
                                 input logic sv, input logic [3:0] s);
        cfg_we    = we;
        cfg_addr  = addr;
        cfg_data  = data;
        arm       = a;
        len_in    = len;
        sym_valid = sv;
        sym_in    = s;
        @(posedge clk);
        #1;
        cfg_we    = 1'b0;
        arm       = 1'b0;
        sym_valid = 1'b0;
    endtask

    task automatic idle_step();
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 4'd0, 1'b0, 4'h0);
    endtask

    task automatic sym_step(input logic [3:0] s);
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b0, 4'd0, 1'b1, s);
    endtask

    task automatic arm_step(input logic [3:0] len);
        applyStimulus(1'b0, 3'd0, 4'h0, 1'b1, len, 1'b0, 4'h0);
    endtask

    task automatic write_step(input logic [2:0] addr, input logic [3:0] data);
        applyStimulus(1'b1, addr, data, 1'b0, 4'd0, 1'b0, 4'h0);
    endtask

    task automatic load_code();
        write_step(3'd0, 4'h3);
        write_step(3'd1, 4'hA);
        write_step(3'd2, 4'h5);
        write_step(3'd3, 4'h1);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_busy"},     busy,       0);
        checkOutput({tag, "_progress"}, progress,   0);
        checkOutput({tag, "_done"},     done,       0);
        checkOutput({tag, "_fail"},     fail,       0);
        checkOutput({tag, "_locked"},   locked,     0);
        checkOutput({tag, "_tries"},    tries_left, 3);
    endtask

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        arm = 1'b0; len_in = '0; sym_valid = 1'b0; sym_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        idle_step();

        // Correct entry
        load_code();
        arm_step(4'd4);
        checkOutput("arm_busy", busy, 1);
        checkOutput("arm_progress", progress, 0);
        sym_step(4'h3);
        checkOutput("ok_progress1", progress, 1);
        sym_step(4'hA);
        sym_step(4'h5);
        checkOutput("ok_progress3", progress, 3);
        checkOutput("ok_done_early", done, 0);
        sym_step(4'h1);
        checkOutput("ok_done", done, 1);
        checkOutput("ok_tries", tries_left, 3);
        idle_step();
        checkOutput("ok_done_one_cycle", done, 0);
        checkOutput("ok_idle_busy", busy, 0);

        // Wrong symbol
        arm_step(4'd4);
        sym_step(4'h3);
        checkOutput("wrong_no_fail_yet", fail, 0);
        sym_step(4'hB);
        checkOutput("wrong_fail", fail, 1);
        checkOutput("wrong_tries", tries_left, 2);
        idle_step();
        checkOutput("wrong_fail_one_cycle", fail, 0);
        checkOutput("wrong_idle_busy", busy, 0);

        // Two more wrong attempts -> lockout
        arm_step(4'd4);
        sym_step(4'h0);
        checkOutput("lock_fail2_tries", tries_left, 1);
        idle_step();
        arm_step(4'd4);
        sym_step(4'h0);
        checkOutput("lock_fail3", fail, 1);
        checkOutput("lock_fail3_tries", tries_left, 0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b0, 3'd0, 4'h0, 1'b1, 4'd4, 1'b1, 4'h3);
            if (i < 16) begin
                checkOutput($sformatf("lock_locked_%0d", i), locked, 1);
                checkOutput($sformatf("lock_tries_%0d", i), tries_left, 0);
            end
        end
        checkOutput("lock_end_locked", locked, 0);
        checkOutput("lock_end_busy", busy, 0);
        checkOutput("lock_end_tries", tries_left, 3);

        // Idle gap in ENTER
        arm_step(4'd4);
        repeat (31) idle_step();
        checkOutput("tmo_31_fail", fail, 0);
        checkOutput("tmo_31_busy", busy, 1);
        idle_step();
`ifdef VAULT_TIMEOUT_EN
        checkOutput("tmo_32_fail", fail, 1);
        checkOutput("tmo_32_tries", tries_left, 2);
`else
        checkOutput("tmo_32_fail", fail, 0);
        checkOutput("tmo_32_busy", busy, 1);
        checkOutput("tmo_32_progress", progress, 0);
        sym_step(4'h7);
        checkOutput("tmo_exit_fail", fail, 1);
        checkOutput("tmo_exit_tries", tries_left, 2);
`endif
        idle_step();
        checkOutput("tmo_idle_busy", busy, 0);

        // Bad lengths
        arm_step(4'd0);
        checkOutput("len0_fail", fail, 1);
        checkOutput("len0_tries", tries_left, 1);
        idle_step();
        arm_step(4'd9);
        checkOutput("len9_fail", fail, 1);
        checkOutput("len9_tries", tries_left, 0);
        idle_step();
        checkOutput("len9_locked", locked, 1);

        // Reset during lockout clears everything, including the table
        rst = 1'b1;
        #2;
        check_reset_values("rst_lockout");
        @(posedge clk);
        #1;
        rst = 1'b0;
        arm_step(4'd1);
        sym_step(4'h0);
        checkOutput("cleared_table_done", done, 1);
        idle_step();

        // Write gating during ENTER
        load_code();
        arm_step(4'd4);
        write_step(3'd1, 4'hF);
        sym_step(4'h3);
        sym_step(4'hA);
        sym_step(4'h5);
        sym_step(4'h1);
        checkOutput("gated_write_done", done, 1);
        idle_step();

        // Write and arm in the same idle cycle
        applyStimulus(1'b1, 3'd0, 4'h9, 1'b1, 4'd1, 1'b0, 4'h0);
        sym_step(4'h9);
        checkOutput("same_cycle_write_done", done, 1);
        idle_step();
        write_step(3'd0, 4'h3);

        // Reset mid-attempt
        arm_step(4'd4);
        sym_step(4'h3);
        sym_step(4'hA);
        checkOutput("mid_progress", progress, 2);
        rst = 1'b1;
        #2;
        check_reset_values("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        load_code();
        arm_step(4'd4);
        sym_step(4'h3);
        sym_step(4'hA);
        sym_step(4'h5);
        sym_step(4'h1);
        checkOutput("fresh_done", done, 1);
        checkOutput("fresh_tries", tries_left, 3);
        idle_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
